pipe_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-stage enable, flush and bubble controls from three event classes:
  - load-use hazards
  - EX-stage branch redirects
  - multi-cycle data-memory handshakes
- Also provides a debug halt, a saturating stall counter and a sticky dmem timeout error.

---
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/handshake inputs and per-stage control outputs exchanged between the
// pipeline datapath (master) and the pipe_ctrl sequencer (slave).
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1addr;
  logic [4:0]       id_rs2addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rdaddr;
  logic             ex_is_load;
  logic             ex_br_taken;
  logic             mem_req;
  logic             dmem_ack;
  logic             halt_req;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             halted;
  logic             dmem_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1addr, id_rs2addr, id_rs1_used, id_rs2_used,
           ex_rdaddr, ex_is_load, ex_br_taken, mem_req, dmem_ack, halt_req,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_bubble, halted, dmem_timeout, stall_cnt
  );

  modport slave (
    input  id_rs1addr, id_rs2addr, id_rs1_used, id_rs2_used,
           ex_rdaddr, ex_is_load, ex_br_taken, mem_req, dmem_ack, halt_req,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_bubble, halted, dmem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage pipeline registers: per-stage enable,
// flush and bubble controls from load-use, branch and dmem-wait events.
module pipe_ctrl #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, ERROR} state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic memstall, lu, stall_now;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic memwb_bubble, halted, dmem_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign memstall = bus.mem_req & ~bus.dmem_ack;
  assign lu = bus.ex_is_load & (bus.ex_rdaddr != 5'd0) &
              ((bus.id_rs1_used & (bus.id_rs1addr == bus.ex_rdaddr)) |
               (bus.id_rs2_used & (bus.id_rs2addr == bus.ex_rdaddr)));

  // In MEM_WAIT the outstanding access is what stalls us, so only the ack matters.
  assign stall_now = (state_q == RUN) ? memstall : ~bus.dmem_ack;

  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_bubble = 1'b1;
    halted       = 1'b0;
    dmem_timeout = 1'b0;

    case (state_q)
      RUN, MEM_WAIT: begin
        if (stall_now) begin
          if (state_q == RUN) begin
            state_d  = MEM_WAIT;
            to_cnt_d = TO_W'(1);
          end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
            state_d = ERROR;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end else begin
          memwb_bubble = 1'b0;
          if (bus.ex_br_taken) begin
            // Wrong-path ID instruction: any load-use match on it is irrelevant.
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
          end else if (lu) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
          end
          to_cnt_d = '0;
          state_d  = bus.halt_req ? HALTED : RUN;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (!bus.halt_req) state_d = RUN;
      end
      ERROR: begin
        dmem_timeout = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_en      = 1'b0;
      idex_flush   = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      halted       = 1'b0;
      dmem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      to_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      if (!pc_en) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_en      = idex_en;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.halted       = halted;
  assign bus.dmem_timeout = dmem_timeout;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each cycle's stimulus queues its expected
// controls and stall count; a negedge monitor pops and compares.
module tb_pipe_ctrl;
  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 4;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, halted, dmem_timeout}
  localparam logic [8:0] NORM = 9'b110101000;
  localparam logic [8:0] MSTL = 9'b000000100;
  localparam logic [8:0] RSTV = 9'b000000100;
  localparam logic [8:0] LU   = 9'b000111000;
  localparam logic [8:0] BR   = 9'b111111000;
  localparam logic [8:0] HALT = 9'b000000110;
  localparam logic [8:0] ERRV = 9'b000000101;

  typedef struct {
    logic [8:0]       ctl;
    logic [CNT_W-1:0] cnt;
    string            nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.TO_W(8), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic ld,
                     input logic br, input logic mreq, input logic ack,
                     input logic halt, input logic rstn, input logic [8:0] ev,
                     input int ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    bus.id_rs1addr  = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs2addr  = rs2;
    bus.id_rs2_used = u2;
    bus.ex_rdaddr   = rd;
    bus.ex_is_load  = ld;
    bus.ex_br_taken = br;
    bus.mem_req     = mreq;
    bus.dmem_ack    = ack;
    bus.halt_req    = halt;
    rst_n           = rstn;
    e.ctl = ev;
    e.cnt = CNT_W'(ec);
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic run(input logic halt, input logic [8:0] ev, input int ec, input string nm);
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, halt, 1'b1, ev, ec, nm);
  endtask

  task automatic mem(input logic ack, input logic halt, input logic [8:0] ev, input int ec,
                     input string nm);
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, ack, halt, 1'b1, ev, ec, nm);
  endtask

  task automatic rst(input logic halt, input string nm);
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, halt, 1'b0, RSTV, 0, nm);
  endtask

  // Monitor: the DUT presents a control vector every cycle.
  initial begin
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
               bus.exmem_en, bus.memwb_bubble, bus.halted, bus.dmem_timeout};
        n_chk++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL %s ctl: got %b want %b", e.nm, act, e.ctl);
        end
        n_chk++;
        if (bus.stall_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL %s stall_cnt: got %0d want %0d", e.nm, bus.stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, want end before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.id_rs1addr  = '0;
    bus.id_rs2addr  = '0;
    bus.id_rs1_used = 1'b0;
    bus.id_rs2_used = 1'b0;
    bus.ex_rdaddr   = '0;
    bus.ex_is_load  = 1'b0;
    bus.ex_br_taken = 1'b0;
    bus.mem_req     = 1'b0;
    bus.dmem_ack    = 1'b0;
    bus.halt_req    = 1'b0;
    rst_n           = 1'b0;

    rst(1'b0, "reset0");
    rst(1'b0, "reset1");
    run(1'b0, NORM, 0, "idle");
    // Load-use on rs1, then the load has moved to MEM
    cyc(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, LU, 0, "lu_rs1");
    run(1'b0, NORM, 1, "lu_after");
    cyc(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NORM, 1, "lu_x0");
    cyc(5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, LU, 1, "lu_rs2");
    cyc(5'd9, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NORM, 2, "lu_unused");
    cyc(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, BR, 2, "br_over_lu");
    run(1'b0, NORM, 2, "br_after");
    // Three stalled cycles then the ack
    mem(1'b0, 1'b0, MSTL, 2, "mw_0");
    mem(1'b0, 1'b0, MSTL, 3, "mw_1");
    mem(1'b0, 1'b0, MSTL, 4, "mw_2");
    mem(1'b1, 1'b0, NORM, 5, "mw_ack");
    run(1'b0, NORM, 5, "mw_after");
    // memstall beats branch; ack cycle applies branch / load-use rules
    cyc(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, MSTL, 5, "ms_over_br");
    cyc(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BR, 6, "ack_br");
    mem(1'b0, 1'b0, MSTL, 6, "mw_lu_0");
    cyc(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, LU, 7, "ack_lu");
    run(1'b0, NORM, 8, "ack_lu_after");
    // Halt from RUN
    run(1'b1, NORM, 8, "halt_req");
    run(1'b1, HALT, 8, "halted_0");
    run(1'b0, HALT, 9, "halt_release");
    run(1'b0, NORM, 10, "halt_resume");
    // Halt raised during MEM_WAIT, ack after 2 more cycles, 5 halted cycles
    mem(1'b0, 1'b0, MSTL, 10, "hmw_0");
    mem(1'b0, 1'b1, MSTL, 11, "hmw_1");
    mem(1'b0, 1'b1, MSTL, 12, "hmw_2");
    mem(1'b1, 1'b1, NORM, 13, "hmw_ack");
    run(1'b1, HALT, 13, "hmw_h0");
    run(1'b1, HALT, 14, "hmw_h1");
    run(1'b1, HALT, 15, "hmw_h2");
    run(1'b1, HALT, 16, "hmw_h3");
    run(1'b0, HALT, 17, "hmw_h4");
    run(1'b0, NORM, 18, "hmw_resume");
    // Halt ignored while the RUN cycle itself is a memstall
    mem(1'b0, 1'b1, MSTL, 18, "hms_0");
    mem(1'b1, 1'b1, NORM, 19, "hms_ack");
    run(1'b0, HALT, 19, "hms_h0");
    run(1'b0, NORM, 20, "hms_resume");
    // Asynchronous reset mid-HALTED
    run(1'b1, NORM, 20, "rh_req");
    run(1'b1, HALT, 20, "rh_h0");
    run(1'b1, HALT, 21, "rh_h1");
    run(1'b1, HALT, 22, "rh_h2");
    rst(1'b1, "rh_reset");
    run(1'b1, NORM, 0, "rh_release");
    run(1'b0, HALT, 0, "rh_h_again");
    run(1'b0, NORM, 1, "rh_resume");
    // stall_cnt saturates at 31
    run(1'b1, NORM, 1, "sat_req");
    for (int i = 0; i < 35; i++) run(1'b1, HALT, (i + 1 > 31) ? 31 : i + 1, "sat");
    run(1'b0, HALT, 31, "sat_release");
    run(1'b0, NORM, 31, "sat_resume");
    // dmem timeout: 4 MEM_WAIT cycles then sticky ERROR
    rst(1'b0, "to_reset");
    run(1'b0, NORM, 0, "to_idle");
    mem(1'b0, 1'b0, MSTL, 0, "to_run");
    mem(1'b0, 1'b0, MSTL, 1, "to_w1");
    mem(1'b0, 1'b0, MSTL, 2, "to_w2");
    mem(1'b0, 1'b0, MSTL, 3, "to_w3");
    mem(1'b0, 1'b0, MSTL, 4, "to_w4");
    mem(1'b0, 1'b0, ERRV, 5, "to_err");
    mem(1'b1, 1'b1, ERRV, 6, "to_late_ack");
    run(1'b0, ERRV, 7, "to_sticky");
    rst(1'b0, "to_clear");
    run(1'b0, NORM, 0, "to_cleared");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
